// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin arbiter sharing one 3-to-8 one-hot select
// decoder among 8 requesters. A grant is held for at most HOLD_MAX cycles,
// and one idle cycle always separates consecutive grants.
// Optional feature macro: RR_DECODE_ARBITER_URGENT_EN (adds 'urgent' input;
// an urgent request from requester 0 wins in IDLE and ignores HOLD_MAX).
module rr_decode_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
`ifdef RR_DECODE_ARBITER_URGENT_EN
  input  logic       urgent,
`endif
  output logic       grant_en,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_onehot,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] last_ptr;
  logic [2:0] rr_winner;
  logic       urgent_take;
  logic       urgent_hold;
  logic       release_now;

  // Round-robin scan: first set request starting just after last_ptr.
  always_comb begin
    logic [2:0] cand;
    logic       found;
    rr_winner = last_ptr;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = 3'(32'(last_ptr) + k);
      if (!found && req[cand]) begin
        rr_winner = cand;
        found     = 1'b1;
      end
    end
  end

  // Urgent override only applies to requester 0 when the feature is built in.
`ifdef RR_DECODE_ARBITER_URGENT_EN
  assign urgent_take = urgent & req[0];
`else
  assign urgent_take = 1'b0;
`endif

  // Release on request drop, or on hold expiry unless this is an urgent grant.
  assign release_now = !req[grant_idx] || (!urgent_hold && (hold_cnt == HOLD_LIM));

  // Arbitration FSM with registered decoder index/enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_en    <= 1'b0;
      grant_idx   <= '0;
      hold_cnt    <= '0;
      last_ptr    <= 3'd7;
      urgent_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            state    <= GRANT;
            grant_en <= 1'b1;
            hold_cnt <= 8'd1;
            if (urgent_take) begin
              grant_idx   <= 3'd0;
              last_ptr    <= 3'd0;
              urgent_hold <= 1'b1;
            end else begin
              grant_idx   <= rr_winner;
              last_ptr    <= rr_winner;
              urgent_hold <= 1'b0;
            end
          end
        end
        GRANT: begin
          if (release_now) begin
            state       <= IDLE;
            grant_en    <= 1'b0;
            urgent_hold <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          grant_en <= 1'b0;
        end
      endcase
    end
  end

  // Decoder output is a pure function of the registered index/enable.
  assign grant_onehot = grant_en ? (8'b0000_0001 << grant_idx) : '0;
  assign busy         = grant_en;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: two instances (HOLD_MAX=4 and
// HOLD_MAX=1) share the same request/reset stimulus and are compared every
// cycle against a behavioural round-robin model.
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
`ifdef RR_DECODE_ARBITER_URGENT_EN
  logic       urgent = 1'b0;
`endif

  logic       en4, busy4, en1, busy1;
  logic [2:0] idx4, idx1;
  logic [7:0] oh4, oh1;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state, one slot per instance.
  int hold_lim [2] = '{4, 1};
  bit m_en   [2];
  int m_idx  [2];
  int m_cnt  [2];
  int m_last [2];

  always #5 clk = ~clk;

  rr_decode_arbiter #(.HOLD_MAX(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
`ifdef RR_DECODE_ARBITER_URGENT_EN
    .urgent       (urgent),
`endif
    .grant_en     (en4),
    .grant_idx    (idx4),
    .grant_onehot (oh4),
    .busy         (busy4)
  );

  rr_decode_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
`ifdef RR_DECODE_ARBITER_URGENT_EN
    .urgent       (urgent),
`endif
    .grant_en     (en1),
    .grant_idx    (idx1),
    .grant_onehot (oh1),
    .busy         (busy1)
  );

  // Advance the model by one clock edge using the values sampled at that edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_en[d]   = 1'b0;
        m_idx[d]  = 0;
        m_cnt[d]  = 0;
        m_last[d] = 7;
      end else if (!m_en[d]) begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_last[d] + k) % 8;
          if (!found && req[c]) begin
            found     = 1'b1;
            m_en[d]   = 1'b1;
            m_idx[d]  = c;
            m_last[d] = c;
            m_cnt[d]  = 1;
          end
        end
      end else if (!req[m_idx[d]] || m_cnt[d] == hold_lim[d]) begin
        m_en[d] = 1'b0;
      end else begin
        m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then compare both instances to the model.
  task automatic cycle(input logic [7:0] r, input logic rn);
    logic [7:0] exp_oh;
    req   = r;
    rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    exp_oh = m_en[0] ? (8'd1 << m_idx[0]) : 8'd0;
    check("en4",   32'(en4),   32'(m_en[0]));
    check("idx4",  32'(idx4),  32'(m_idx[0]));
    check("oh4",   32'(oh4),   32'(exp_oh));
    check("busy4", 32'(busy4), 32'(m_en[0]));
    exp_oh = m_en[1] ? (8'd1 << m_idx[1]) : 8'd0;
    check("en1",   32'(en1),   32'(m_en[1]));
    check("idx1",  32'(idx1),  32'(m_idx[1]));
    check("oh1",   32'(oh1),   32'(exp_oh));
    check("busy1", 32'(busy1), 32'(m_en[1]));
  endtask

  initial begin
    logic [7:0] r;
    logic       rn;
    int         len;

    for (int d = 0; d < 2; d++) begin
      m_en[d] = 1'b0; m_idx[d] = 0; m_cnt[d] = 0; m_last[d] = 7;
    end
    #1;

    // Reset, then idle with no requests.
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    repeat (5) cycle(8'h00, 1'b1);

    // All requesting: full rotation 0..7 then back to 0.
    repeat (45) cycle(8'hFF, 1'b1);

    // Bits 2 and 5: drop req[2] after three grant cycles, 5 follows.
    cycle(8'h00, 1'b0);
    repeat (3) cycle(8'h24, 1'b1);
    repeat (5) cycle(8'h20, 1'b1);
    repeat (2) cycle(8'h00, 1'b1);

    // Sole requester 7, then add requester 0 to check pointer wrap.
    cycle(8'h00, 1'b0);
    repeat (8) cycle(8'h80, 1'b1);
    repeat (6) cycle(8'h81, 1'b1);
    repeat (2) cycle(8'h00, 1'b1);

    // Reset in the 2nd cycle of a grant to idx 3, then re-grant.
    cycle(8'h00, 1'b0);
    cycle(8'h08, 1'b1);
    cycle(8'h08, 1'b1);
    cycle(8'h08, 1'b0);
    repeat (4) cycle(8'h08, 1'b1);

    // Randomized request patterns with occasional resets.
    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       r = 8'($urandom);
        1:       r = 8'($urandom) & 8'($urandom);
        2:       r = 8'd1 << $urandom_range(0, 7);
        default: r = 8'h00;
      endcase
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        rn = ($urandom_range(0, 59) != 0);
        cycle(r, rn);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
